spi_byte_tx: RTL and testbench

//  Serial back end for the ILI9341 command path: consumes one byte request (send/data/dc/cs)

---
 rtl/pkg_ili9341.sv | 30 +++
 rtl/spi_clk_div.sv | 42 ++++
 rtl/spi_byte_tx.sv | 156 +++++++++++++++
 tb/tb_spi_byte_tx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_ili9341.sv
// ---------------------------------------------------------------------------
// pkg_ili9341
// Shared definitions for the ILI9341 panel command path.
//   LOW / HIGH / NO_DATA   : generic pin levels and the empty data byte
//   SCK_IDLE / CS_IDLE / DC_IDLE : panel SPI pin levels while no byte is active
//   spi_state_t            : states of the serial byte transmitter
//   div_cnt_w()            : width of a divide-by-N down counter (at least 1)
// ---------------------------------------------------------------------------
package pkg_ili9341;

    localparam logic       LOW     = 1'b0;
    localparam logic       HIGH    = 1'b1;
    localparam logic [7:0] NO_DATA = 8'h00;

    localparam logic SCK_IDLE = LOW;
    localparam logic CS_IDLE  = HIGH;
    localparam logic DC_IDLE  = HIGH;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_LOW,
        SPI_HIGH,
        SPI_DONE
    } spi_state_t;

    function automatic int div_cnt_w(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// ---------------------------------------------------------------------------
// spi_clk_div
// Phase timer for the SPI transmitter. While i_ena is high, o_tick pulses for
// one cycle every CLK_DIV cycles; the first tick comes CLK_DIV cycles after
// i_ena rises. The counter reloads whenever i_ena is low.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous, active-high reset
//   i_ena  in  count enable (high while an SCK phase is running)
//   o_tick out one-cycle end-of-phase strobe
// ---------------------------------------------------------------------------
module spi_clk_div
    import pkg_ili9341::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ena,
    output logic o_tick
);

    localparam int            CW     = div_cnt_w(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // A tick both ends the current phase and reloads for the next one, so
    // consecutive phases are exactly CLK_DIV cycles long with no gap.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || !i_ena || o_tick) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign o_tick = i_ena && (cnt == '0);

endmodule

// File: rtl/spi_byte_tx.sv
// ---------------------------------------------------------------------------
// spi_byte_tx
// Serial back end for the ILI9341 command path. Accepts one byte request and
// shifts it MSB-first onto the panel SPI pins (mode 0: SCK idles low, MOSI
// set up while SCK is low, sampled by the panel on the rising edge).
// Every output is a register; no combinational path from inputs to pins.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   i_send       in   byte request, held by upstream until o_byte_sent
//   i_data       in   byte to shift (DW bits)
//   i_dc         in   D/C level for this byte (0 command, 1 data)
//   i_cs         in   CS level for this byte (0 selected)
//   o_byte_sent  out  one-cycle pulse after the last bit's SCK high phase
//   o_busy       out  high whenever a byte is in flight
//   o_sck        out  SPI clock, idle low
//   o_mosi       out  SPI data
//   o_dc         out  panel D/C pin, idle high
//   o_cs         out  panel CS pin, idle high
//   o_byte_cnt   out  16-bit count of o_byte_sent pulses, wraps
//                     (present only when SPI_TX_BYTE_CNT_EN is defined)
// Configuration macro: SPI_TX_BYTE_CNT_EN
// ---------------------------------------------------------------------------
module spi_byte_tx
    import pkg_ili9341::*;
#(
    parameter int DW      = 8,
    parameter int CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_send,
    input  logic [DW-1:0] i_data,
    input  logic          i_dc,
    input  logic          i_cs,
    output logic          o_byte_sent,
    output logic          o_busy,
    output logic          o_sck,
    output logic          o_mosi,
    output logic          o_dc,
    output logic          o_cs
`ifdef SPI_TX_BYTE_CNT_EN
    ,
    output logic [15:0]   o_byte_cnt
`endif
);

    localparam int BW = (DW > 1) ? $clog2(DW) : 1;

    spi_state_t    state, state_next;
    logic [DW-1:0] shreg, shreg_next;
    logic [BW-1:0] bit_cnt, bit_cnt_next;
    logic          dc_hold, dc_next;
    logic          cs_hold, cs_next;
    logic          phase_active;
    logic          tick;

    assign phase_active = (state == SPI_LOW) || (state == SPI_HIGH);

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .i_ena  (phase_active),
        .o_tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SPI_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Inputs are only looked at in IDLE, so anything upstream does while a
    // byte is in flight has no effect and nothing is ever queued.
    // NOTE: every signal driven here gets its hold value first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        dc_next      = dc_hold;
        cs_next      = cs_hold;
        case (state)
            SPI_IDLE: begin
                if (i_send) begin
                    state_next   = SPI_LOW;
                    shreg_next   = i_data;
                    bit_cnt_next = BW'(DW - 1);
                    dc_next      = i_dc;
                    cs_next      = i_cs;
                end
            end
            SPI_LOW: begin
                if (tick) state_next = SPI_HIGH;
            end
            SPI_HIGH: begin
                if (tick) begin
                    if (bit_cnt == '0) begin
                        state_next = SPI_DONE;
                    end else begin
                        state_next   = SPI_LOW;
                        shreg_next   = shreg << 1;
                        bit_cnt_next = bit_cnt - 1'b1;
                    end
                end
            end
            SPI_DONE: state_next = SPI_IDLE;
            default:  state_next = SPI_IDLE;
        endcase
    end

    // Pins are decoded from the next state so they change on the same edge
    // as the state register. MOSI only moves when entering LOW (SCK falling
    // or already low), which keeps it stable across every rising SCK edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= DW'(NO_DATA);
            bit_cnt     <= '0;
            dc_hold     <= DC_IDLE;
            cs_hold     <= CS_IDLE;
            o_byte_sent <= LOW;
            o_busy      <= LOW;
            o_sck       <= SCK_IDLE;
            o_mosi      <= LOW;
            o_dc        <= DC_IDLE;
            o_cs        <= CS_IDLE;
        end else begin
            shreg       <= shreg_next;
            bit_cnt     <= bit_cnt_next;
            dc_hold     <= dc_next;
            cs_hold     <= cs_next;
            o_byte_sent <= (state_next == SPI_DONE);
            o_busy      <= (state_next != SPI_IDLE);
            o_sck       <= (state_next == SPI_HIGH) ? HIGH : SCK_IDLE;
            o_mosi      <= (state_next == SPI_IDLE) ? LOW     : shreg_next[DW-1];
            o_dc        <= (state_next == SPI_IDLE) ? DC_IDLE : dc_next;
            o_cs        <= (state_next == SPI_IDLE) ? CS_IDLE : cs_next;
        end
    end

`ifdef SPI_TX_BYTE_CNT_EN
    // Counts completed bytes; a reset during the pulse cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_byte_cnt <= '0;
        end else if (o_byte_sent) begin
            o_byte_cnt <= o_byte_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_byte_tx.sv
// ---------------------------------------------------------------------------
// tb_spi_byte_tx
// Self-checking bench for spi_byte_tx. Two lanes: CLK_DIV=4 and CLK_DIV=1.
// Each lane has an edge-count reference model (cycles since the capturing
// edge) that predicts every pin each cycle, and a scoreboard: the expected
// byte is queued when a request is accepted and popped on o_byte_sent, where
// it is compared against the bits collected from MOSI on rising SCK.
// Optional feature under test when defined: SPI_TX_BYTE_CNT_EN.
// ---------------------------------------------------------------------------
module tb_spi_byte_tx;

    localparam int DW = 8;
    localparam int NL = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
        logic       cs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       send [NL];
    logic [7:0] data [NL];
    logic       dc   [NL];
    logic       cs   [NL];
    logic       chk_en = 1'b0;
    int         cyc = 0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    for (genvar k = 0; k < NL; k++) begin : g_lane
        localparam int DIV = (k == 0) ? 4 : 1;
        localparam int N   = 2 * DW * DIV;

        logic byte_sent, busy, sck, mosi, dc_pin, cs_pin;
`ifdef SPI_TX_BYTE_CNT_EN
        logic [15:0] byte_cnt;
`endif

        spi_byte_tx #(
            .DW      (DW),
            .CLK_DIV (DIV)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .i_send      (send[k]),
            .i_data      (data[k]),
            .i_dc        (dc[k]),
            .i_cs        (cs[k]),
            .o_byte_sent (byte_sent),
            .o_busy      (busy),
            .o_sck       (sck),
            .o_mosi      (mosi),
            .o_dc        (dc_pin),
            .o_cs        (cs_pin)
`ifdef SPI_TX_BYTE_CNT_EN
            ,
            .o_byte_cnt  (byte_cnt)
`endif
        );

        // t: edges since the capturing edge, -1 when idle.
        // t in [0,N): shifting; t == N: pulse cycle; next edge back to idle,
        // and only the edge after that may capture again.
        int         t = -1;
        exp_t       cur = '0;
        exp_t       exp_q [$];
        logic [7:0] got = '0;
        int         nbits = 0;
        int         pulses = 0;
        logic       prev_sck = 1'b0;

        always @(posedge clk) begin
            if (rst) begin
                t <= -1;
                exp_q.delete();
            end else if (t < 0) begin
                if (send[k]) begin
                    t   <= 0;
                    cur <= '{data[k], dc[k], cs[k]};
                    exp_q.push_back('{data[k], dc[k], cs[k]});
                end
            end else if (t == N) begin
                t <= -1;
            end else begin
                t <= t + 1;
            end
        end

        always @(negedge clk) begin
            prev_sck <= sck;
            if (rst) begin
                nbits <= 0;
                got   <= '0;
            end else if (chk_en) begin
                check($sformatf("L%0d_busy", k), busy, (t >= 0));
                check($sformatf("L%0d_sent", k), byte_sent, (t == N));
                check($sformatf("L%0d_sck", k), sck, (t >= 0 && t < N) ? (t / DIV) % 2 : 0);
                check($sformatf("L%0d_cs", k), cs_pin, (t >= 0) ? cur.cs : 1'b1);
                check($sformatf("L%0d_dc", k), dc_pin, (t >= 0) ? cur.dc : 1'b1);
                if (t >= 0 && t < N)
                    check($sformatf("L%0d_mosi", k), mosi, cur.data[DW - 1 - t / (2 * DIV)]);
                else if (t < 0)
                    check($sformatf("L%0d_mosi_idle", k), mosi, 1'b0);

                if (sck && !prev_sck) begin
                    got   <= {got[6:0], mosi};
                    nbits <= nbits + 1;
                end
                if (byte_sent) begin
                    check($sformatf("L%0d_q_depth", k), exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        check($sformatf("L%0d_byte", k), got, exp_q[0].data);
                        void'(exp_q.pop_front());
                    end
                    check($sformatf("L%0d_nbits", k), nbits, 8);
                    nbits  <= 0;
                    got    <= '0;
                    pulses <= pulses + 1;
                end
            end
        end
    end

    function automatic logic sent_now(input int k);
        return (k == 0) ? g_lane[0].byte_sent : g_lane[1].byte_sent;
    endfunction

    function automatic int pulses_of(input int k);
        return (k == 0) ? g_lane[0].pulses : g_lane[1].pulses;
    endfunction

    // Waits for o_byte_sent on lane k; returns the cycle stamp of the pulse.
    task automatic wait_pulse(input int k, input int budget, output int at);
        bit seen;
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (sent_now(k)) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        check($sformatf("L%0d_pulse_seen", k), seen, 1);
    endtask

    task automatic start_byte(input int k, input logic [7:0] d, input logic d_c, input logic c_s,
                              output int start);
        @(negedge clk);
        start   = cyc;
        send[k] = 1'b1;
        data[k] = d;
        dc[k]   = d_c;
        cs[k]   = c_s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         start, at, prev, p0;
        bit         seen;
        logic [7:0] b2b [3];

        b2b = '{8'h2A, 8'h00, 8'hEF};
        rst = 1'b1;
        for (int k = 0; k < NL; k++) begin
            send[k] = 1'b0;
            data[k] = 8'h00;
            dc[k]   = 1'b0;
            cs[k]   = 1'b0;
        end
        repeat (3) @(negedge clk);

        check("rst_sent", g_lane[0].byte_sent, 0);
        check("rst_busy", g_lane[0].busy, 0);
        check("rst_sck",  g_lane[0].sck, 0);
        check("rst_mosi", g_lane[0].mosi, 0);
        check("rst_dc",   g_lane[0].dc_pin, 1);
        check("rst_cs",   g_lane[0].cs_pin, 1);
        rst    = 1'b0;
        chk_en = 1'b1;

        // 0xA5 as a command byte, CS selected; pulse 64 edges after capture.
        p0 = pulses_of(0);
        start_byte(0, 8'hA5, 1'b0, 1'b0, start);
        wait_pulse(0, 200, at);
        check("a5_latency", at - (start + 1), 64);
        send[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("a5_pulses", pulses_of(0) - p0, 1);

        // Upstream holds i_send and presents the next byte after each pulse.
        // Pulses land 66 edges apart: 65 quiet cycles between them.
        p0   = pulses_of(0);
        prev = -1;
        start_byte(0, b2b[0], 1'b1, 1'b0, start);
        for (int i = 0; i < 3; i++) begin
            wait_pulse(0, 200, at);
            if (i > 0) check("b2b_gap", at - prev, 66);
            prev = at;
            if (i < 2) data[0] = b2b[i + 1];
            else       send[0] = 1'b0;
        end
        repeat (4) @(negedge clk);
        check("b2b_pulses", pulses_of(0) - p0, 3);

        // Inputs churn while busy: byte stays 0x0F, one pulse only.
        p0 = pulses_of(0);
        start_byte(0, 8'h0F, 1'b1, 1'b0, start);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            send[0] = ~send[0];
            data[0] = 8'hFF;
            dc[0]   = ~dc[0];
            cs[0]   = i[0];
        end
        wait_pulse(0, 200, at);
        send[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("churn_pulses", pulses_of(0) - p0, 1);

        // Reset right after the fourth rising SCK edge of a byte.
        p0 = pulses_of(0);
        start_byte(0, 8'h3C, 1'b0, 1'b0, start);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (g_lane[0].nbits >= 4) seen = 1'b1;
        end
        check("abort_sck4_seen", seen, 1);
        rst     = 1'b1;
        send[0] = 1'b0;
        @(negedge clk);
        check("abort_cs",   g_lane[0].cs_pin, 1);
        check("abort_sck",  g_lane[0].sck, 0);
        check("abort_busy", g_lane[0].busy, 0);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("abort_no_pulse", pulses_of(0) - p0, 0);

        // CLK_DIV=1 lane: 2-cycle SCK period, pulse at edge 16.
        p0 = pulses_of(1);
        start_byte(1, 8'h81, 1'b1, 1'b0, start);
        wait_pulse(1, 60, at);
        check("div1_latency", at - (start + 1), 16);
        send[1] = 1'b0;
        repeat (4) @(negedge clk);
        check("div1_pulses", pulses_of(1) - p0, 1);

`ifdef SPI_TX_BYTE_CNT_EN
        check("cnt_after_rst", g_lane[0].byte_cnt, 16'h0000);
        force g_lane[0].u_dut.o_byte_cnt = 16'hFFFF;
        @(negedge clk);
        release g_lane[0].u_dut.o_byte_cnt;
        @(negedge clk);
        check("cnt_preload", g_lane[0].byte_cnt, 16'hFFFF);
        start_byte(0, 8'h55, 1'b1, 1'b0, start);
        wait_pulse(0, 200, at);
        send[0] = 1'b0;
        @(negedge clk);
        check("cnt_wrap", g_lane[0].byte_cnt, 16'h0000);
        start_byte(0, 8'h3A, 1'b1, 1'b0, start);
        wait_pulse(0, 200, at);
        send[0] = 1'b0;
        @(negedge clk);
        check("cnt_incr", g_lane[0].byte_cnt, 16'h0001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("cnt_rst", g_lane[0].byte_cnt, 16'h0000);
`endif

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
